logic_op_scheduler: RTL

Shares one bit-sliced bitwise logic unit (AND/NAND/OR/NOR/XOR/XNOR/NOT) between two requesters. It arbitrates round-robin, accepts one operation at a time, and evaluates it SLICE bits per cycle over WIDTH/SLICE cycles. It returns the result on a valid/ready response channel tagged with the requester ID. It sits between the two command sources and the logic datapath and is the only block that drives that datapath.

---
 rtl/logic_op_scheduler_pkg.sv | 25 ++
 rtl/logic_op_scheduler_slice_unit.sv | 32 +++
 rtl/logic_op_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/logic_op_scheduler_pkg.sv
// Shared opcode encodings, FSM state type and sizing helper for the
// bit-sliced logic scheduler.
package logic_op_scheduler_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slice counter width; a single-slice configuration still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logic_op_scheduler_slice_unit.sv
// Combinational bitwise logic evaluated over one SLICE-bit chunk of the operands.
module logic_slice_unit
  import logic_op_scheduler_pkg::*;
#(
  parameter int SLICE = 2
) (
  input  logic [2:0]       op_i,
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic [SLICE-1:0] y_o,
  output logic             err_o
);

  always_comb begin
    y_o   = '0;
    err_o = 1'b0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_OR:   y_o = a_i | b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_XOR:  y_o = a_i ^ b_i;
      OP_XNOR: y_o = a_i ~^ b_i;
      OP_NOT:  y_o = ~a_i;
      default: begin
        y_o   = '0;
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler sharing one bit-sliced logic unit between two requesters;
// each accepted operation is evaluated SLICE bits per cycle and returned tagged with its id.
module logic_op_scheduler
  import logic_op_scheduler_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_in,
  output logic             req0_ready_out,
  input  logic [2:0]       req0_op_in,
  input  logic [WIDTH-1:0] req0_a_in,
  input  logic [WIDTH-1:0] req0_b_in,
  input  logic             req1_valid_in,
  output logic             req1_ready_out,
  input  logic [2:0]       req1_op_in,
  input  logic [WIDTH-1:0] req1_a_in,
  input  logic [WIDTH-1:0] req1_b_in,
  output logic             rsp_valid_out,
  input  logic             rsp_ready_in,
  output logic             rsp_id_out,
  output logic [WIDTH-1:0] rsp_y_out,
  output logic             rsp_err_out
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = cnt_width(N);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             err_acc_q, err_acc_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;

  logic             grant0_s, grant1_s;
  logic             accept_s, eval_s, finish_s;
  logic [SLICE-1:0] a_slice_s, b_slice_s, y_slice_s;
  logic             err_slice_s;

  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid_in && req1_valid_in) begin
      grant0_s = last_grant_q;
      grant1_s = ~last_grant_q;
    end else if (req0_valid_in) begin
      grant0_s = 1'b1;
    end else if (req1_valid_in) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign accept_s = (state_q == ST_IDLE) && (grant0_s || grant1_s);
  assign eval_s   = (state_q == ST_BUSY) && !last_q;
  assign finish_s = (state_q == ST_BUSY) && last_q;

  assign a_slice_s = a_q[cnt_q*SLICE +: SLICE];
  assign b_slice_s = b_q[cnt_q*SLICE +: SLICE];

  logic_slice_unit #(.SLICE(SLICE)) u_slice (
    .op_i  (op_q),
    .a_i   (a_slice_s),
    .b_i   (b_slice_s),
    .y_o   (y_slice_s),
    .err_o (err_slice_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = accept_s ? ST_BUSY : ST_IDLE;
      ST_BUSY: state_d = last_q ? ST_DONE : ST_BUSY;
      ST_DONE: state_d = rsp_ready_in ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is a same-cycle grant, forced low while reset is asserted.
  always_comb begin
    req0_ready_out = (state_q == ST_IDLE) && grant0_s && !rst;
    req1_ready_out = (state_q == ST_IDLE) && grant1_s && !rst;
    rsp_valid_out  = (state_q == ST_DONE);
    rsp_id_out     = rsp_id_q;
    rsp_y_out      = rsp_y_q;
    rsp_err_out    = rsp_err_q;
  end

  // last_q marks that the final slice is in acc_q; the next BUSY cycle publishes it.
  always_comb begin
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    acc_d        = acc_q;
    err_acc_d    = err_acc_q;
    rsp_y_d      = rsp_y_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    if (accept_s) begin
      last_grant_d = grant1_s;
      op_d         = grant1_s ? req1_op_in : req0_op_in;
      a_d          = grant1_s ? req1_a_in : req0_a_in;
      b_d          = grant1_s ? req1_b_in : req0_b_in;
      id_d         = grant1_s;
      cnt_d        = '0;
      last_d       = 1'b0;
      acc_d        = '0;
      err_acc_d    = 1'b0;
    end else if (eval_s) begin
      acc_d[cnt_q*SLICE +: SLICE] = y_slice_s;
      err_acc_d = err_acc_q | err_slice_s;
      last_d    = (cnt_q == CW'(N - 1));
      cnt_d     = (cnt_q == CW'(N - 1)) ? cnt_q : cnt_q + CW'(1);
    end else if (finish_s) begin
      rsp_y_d   = acc_q;
      rsp_id_d  = id_q;
      rsp_err_d = err_acc_q;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      op_q         <= 3'd0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      acc_q        <= '0;
      err_acc_q    <= 1'b0;
      rsp_y_q      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      acc_q        <= acc_d;
      err_acc_q    <= err_acc_d;
      rsp_y_q      <= rsp_y_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule
